// File: rtl/regulator_trim_controller_if.sv
// Bus between the trim calibration controller and its host/regulator.
// The host side drives start/abort and the comparator lines; the controller drives trim and status.
interface regulator_trim_controller_if;
   logic       start;
   logic       abort;
   logic       cmp_hi;
   logic       cmp_lo;
   logic [3:0] trim;
   logic       busy;
   logic       done;
   logic       fail;
   logic [1:0] fail_code;
   logic [4:0] steps_used;

   modport master (
      output start, abort, cmp_hi, cmp_lo,
      input  trim, busy, done, fail, fail_code, steps_used
   );

   modport slave (
      input  start, abort, cmp_hi, cmp_lo,
      output trim, busy, done, fail, fail_code, steps_used
   );
endinterface

// File: rtl/regulator_trim_controller.sv
// Successive trim calibration: nudges a signed 4-bit regulator trim code one step at a time
// until both window comparators report in-window, with settle delay, rail and step-limit checks.
module regulator_trim_controller #(
   parameter int                 SETTLE_CYCLES = 16,
   parameter int                 MAX_STEPS     = 15,
   parameter logic signed [3:0]  TRIM_INIT     = 4'sd0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   regulator_trim_controller_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SAMPLE = 3'd2,
      DONE   = 3'd3,
      FAIL   = 3'd4
   } state_t;

   localparam logic [7:0]        SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [4:0]        STEP_LIMIT    = 5'(MAX_STEPS);
   localparam logic signed [3:0] TRIM_MAX      = 4'sb0111;
   localparam logic signed [3:0] TRIM_MIN      = 4'sb1000;

   state_t            state_q, state_d;
   logic signed [3:0] trim_q, trim_d;
   logic [4:0]        steps_q, steps_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        code_q, code_d;
   logic [1:0]        hi_sync_q, lo_sync_q;
   logic              hi_s, lo_s;

   // Comparators are asynchronous to clk; only the second flop is ever consumed.
   assign hi_s = hi_sync_q[1];
   assign lo_s = lo_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         trim_q    <= TRIM_INIT;
         steps_q   <= 5'd0;
         cnt_q     <= 8'd0;
         code_q    <= 2'd0;
         hi_sync_q <= 2'b00;
         lo_sync_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         trim_q    <= trim_d;
         steps_q   <= steps_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         hi_sync_q <= {hi_sync_q[0], bus.cmp_hi};
         lo_sync_q <= {lo_sync_q[0], bus.cmp_lo};
      end
   end

   always_comb begin
      state_d = state_q;
      trim_d  = trim_q;
      steps_d = steps_q;
      cnt_d   = cnt_q;
      code_d  = code_q;

      if (bus.abort) begin
         // Abort keeps trim and step count so the last applied code stays visible.
         state_d = IDLE;
         code_d  = 2'd0;
      end else begin
         case (state_q)
            IDLE, DONE, FAIL: begin
               if (bus.start) begin
                  state_d = SETTLE;
                  trim_d  = TRIM_INIT;
                  steps_d = 5'd0;
                  cnt_d   = SETTLE_RELOAD;
                  code_d  = 2'd0;
               end
            end
            SETTLE: begin
               if (cnt_q == 8'd0) begin
                  state_d = SAMPLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            SAMPLE: begin
               if (hi_s && lo_s) begin
                  state_d = FAIL;
                  code_d  = 2'd3;
               end else if (!hi_s && !lo_s) begin
                  state_d = DONE;
               end else if ((lo_s && trim_q == TRIM_MAX) || (hi_s && trim_q == TRIM_MIN)) begin
                  state_d = FAIL;
                  code_d  = 2'd1;
               end else if (steps_q == STEP_LIMIT) begin
                  state_d = FAIL;
                  code_d  = 2'd2;
               end else begin
                  trim_d  = lo_s ? (trim_q + 4'sd1) : (trim_q - 4'sd1);
                  steps_d = steps_q + 5'd1;
                  cnt_d   = SETTLE_RELOAD;
                  state_d = SETTLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.trim       = trim_q;
   assign bus.busy       = (state_q == SETTLE) || (state_q == SAMPLE);
   assign bus.done       = (state_q == DONE);
   assign bus.fail       = (state_q == FAIL);
   assign bus.fail_code  = code_q;
   assign bus.steps_used = steps_q;

endmodule

// File: tb/tb_regulator_trim_controller.sv
// Directed bench: convergence, rail fail, step limit, invalid comparator, abort and reset cases.
module tb_regulator_trim_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // dut1 uses default parameters, dut2 uses MAX_STEPS=2
   logic start1 = 1'b0, abort1 = 1'b0, hi1 = 1'b0, lo1 = 1'b0, model_en = 1'b0;
   logic start2 = 1'b0, abort2 = 1'b0, hi2 = 1'b0, lo2 = 1'b0;

   regulator_trim_controller_if ifc1 ();
   regulator_trim_controller_if ifc2 ();

   // Regulator model: 3 trim steps below target, so cmp_lo holds until trim reaches +3
   assign ifc1.start  = start1;
   assign ifc1.abort  = abort1;
   assign ifc1.cmp_lo = model_en ? ($signed(ifc1.trim) < 4'sd3) : lo1;
   assign ifc1.cmp_hi = model_en ? ($signed(ifc1.trim) > 4'sd3) : hi1;

   assign ifc2.start  = start2;
   assign ifc2.abort  = abort2;
   assign ifc2.cmp_lo = lo2;
   assign ifc2.cmp_hi = hi2;

   regulator_trim_controller dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc1)
   );

   regulator_trim_controller #(.MAX_STEPS(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start1();
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
   endtask

   task automatic pulse_abort1();
      @(negedge clk);
      abort1 = 1'b1;
      @(posedge clk);
      #1;
      abort1 = 1'b0;
   endtask

   task automatic pulse_both1();
      @(negedge clk);
      start1 = 1'b1;
      abort1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      abort1 = 1'b0;
   endtask

   task automatic pulse_start2();
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
   endtask

   initial begin
      // ---- reset state
      tick(3);
      check("rst_trim",  32'(ifc1.trim), 32'h0);
      check("rst_busy",  32'(ifc1.busy), 32'h0);
      check("rst_done",  32'(ifc1.done), 32'h0);
      check("rst_fail",  32'(ifc1.fail), 32'h0);
      check("rst_code",  32'(ifc1.fail_code), 32'h0);
      check("rst_steps", 32'(ifc1.steps_used), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(5);
      check("idle_after_rst_busy", 32'(ifc1.busy), 32'h0);

      // ---- step limit on dut2: cmp_lo held, MAX_STEPS=2
      lo2 = 1'b1;
      tick(3);
      pulse_start2();
      check("lim_busy", 32'(ifc2.busy), 32'h1);
      tick(17);
      check("lim_trim1", 32'(ifc2.trim), 32'h1);
      tick(17);
      check("lim_trim2", 32'(ifc2.trim), 32'h2);
      tick(17);
      check("lim_fail",  32'(ifc2.fail), 32'h1);
      check("lim_code",  32'(ifc2.fail_code), 32'h2);
      check("lim_trim",  32'(ifc2.trim), 32'h2);
      check("lim_steps", 32'(ifc2.steps_used), 32'h2);
      check("lim_busy0", 32'(ifc2.busy), 32'h0);

      // ---- convergence with regulator model, start while busy ignored
      model_en = 1'b1;
      tick(3);
      pulse_start1();
      check("conv_busy",   32'(ifc1.busy), 32'h1);
      check("conv_trim0",  32'(ifc1.trim), 32'h0);
      tick(16);
      check("conv_trim0_late", 32'(ifc1.trim), 32'h0);
      tick(1);
      check("conv_trim1",  32'(ifc1.trim), 32'h1);
      check("conv_steps1", 32'(ifc1.steps_used), 32'h1);
      pulse_start1();
      check("ign_start_trim",  32'(ifc1.trim), 32'h1);
      check("ign_start_steps", 32'(ifc1.steps_used), 32'h1);
      tick(15);
      check("conv_trim1_late", 32'(ifc1.trim), 32'h1);
      tick(1);
      check("conv_trim2",  32'(ifc1.trim), 32'h2);
      tick(17);
      check("conv_trim3",  32'(ifc1.trim), 32'h3);
      check("conv_steps3", 32'(ifc1.steps_used), 32'h3);
      tick(17);
      check("conv_done",   32'(ifc1.done), 32'h1);
      check("conv_fail",   32'(ifc1.fail), 32'h0);
      check("conv_busy0",  32'(ifc1.busy), 32'h0);
      check("conv_steps",  32'(ifc1.steps_used), 32'h3);
      tick(5);
      check("conv_hold_trim", 32'(ifc1.trim), 32'h3);
      check("conv_hold_done", 32'(ifc1.done), 32'h1);

      // ---- cmp_hi held: walk down to -8 rail
      model_en = 1'b0;
      hi1 = 1'b1;
      lo1 = 1'b0;
      tick(3);
      pulse_start1();
      check("rail_done_clr", 32'(ifc1.done), 32'h0);
      check("rail_trim0",    32'(ifc1.trim), 32'h0);
      tick(17);
      check("rail_trim_m1",  32'(ifc1.trim), 32'hF);
      tick(119);
      check("rail_trim_m8",  32'(ifc1.trim), 32'h8);
      check("rail_steps8b",  32'(ifc1.steps_used), 32'h8);
      check("rail_busy",     32'(ifc1.busy), 32'h1);
      tick(17);
      check("rail_fail",  32'(ifc1.fail), 32'h1);
      check("rail_done",  32'(ifc1.done), 32'h0);
      check("rail_code",  32'(ifc1.fail_code), 32'h1);
      check("rail_steps", 32'(ifc1.steps_used), 32'h8);
      check("rail_trim",  32'(ifc1.trim), 32'h8);

      // ---- both comparators high at first sample
      lo1 = 1'b1;
      tick(3);
      pulse_start1();
      check("inv_fail_clr", 32'(ifc1.fail), 32'h0);
      check("inv_code_clr", 32'(ifc1.fail_code), 32'h0);
      tick(17);
      check("inv_fail",  32'(ifc1.fail), 32'h1);
      check("inv_code",  32'(ifc1.fail_code), 32'h3);
      check("inv_trim",  32'(ifc1.trim), 32'h0);
      check("inv_steps", 32'(ifc1.steps_used), 32'h0);

      // ---- abort from FAIL clears status
      pulse_abort1();
      check("abf_fail", 32'(ifc1.fail), 32'h0);
      check("abf_code", 32'(ifc1.fail_code), 32'h0);

      // ---- abort mid-SETTLE after two steps
      hi1 = 1'b0;
      tick(3);
      pulse_start1();
      tick(34);
      check("ab_trim2", 32'(ifc1.trim), 32'h2);
      tick(3);
      pulse_abort1();
      check("ab_busy",  32'(ifc1.busy), 32'h0);
      check("ab_done",  32'(ifc1.done), 32'h0);
      check("ab_fail",  32'(ifc1.fail), 32'h0);
      check("ab_trim",  32'(ifc1.trim), 32'h2);
      check("ab_steps", 32'(ifc1.steps_used), 32'h2);
      tick(40);
      check("ab_hold_trim", 32'(ifc1.trim), 32'h2);
      check("ab_hold_busy", 32'(ifc1.busy), 32'h0);

      // ---- start and abort together from IDLE
      pulse_both1();
      check("sa_busy",  32'(ifc1.busy), 32'h0);
      check("sa_trim",  32'(ifc1.trim), 32'h2);
      check("sa_steps", 32'(ifc1.steps_used), 32'h2);
      tick(2);
      check("sa_busy_late", 32'(ifc1.busy), 32'h0);

      // ---- asynchronous reset mid-SETTLE
      pulse_start1();
      tick(20);
      check("rs_pre_trim", 32'(ifc1.trim), 32'h1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs_trim",  32'(ifc1.trim), 32'h0);
      check("rs_busy",  32'(ifc1.busy), 32'h0);
      check("rs_steps", 32'(ifc1.steps_used), 32'h0);
      check("rs_code",  32'(ifc1.fail_code), 32'h0);
      tick(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick(40);
      check("rs_hold_trim", 32'(ifc1.trim), 32'h0);
      check("rs_hold_busy", 32'(ifc1.busy), 32'h0);
      check("rs_hold_done", 32'(ifc1.done), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regulator_trim_controller.md
REGULATOR_TRIM_CONTROLLER -- requirements
Module: regulator_trim_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, clocks waited after each trim change before sampling comparators (legal range 3..255).
REQ-002 Parameter MAX_STEPS, default 15, maximum trim adjustments per calibration run (legal range 1..31).
REQ-003 Parameter TRIM_INIT, default 0, signed 4-bit trim code applied at calibration start.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  single-cycle pulse requesting a calibration run.
REQ-007 abort  input  1  single-cycle pulse cancelling a run.
REQ-008 cmp_hi  input  1  asynchronous analog comparator output; 1 = regulator vout above target window.
REQ-009 cmp_lo  input  1  asynchronous analog comparator output; 1 = regulator vout below target window.
REQ-010 trim  output  4  signed two's-complement trim code driving the regulator trim port; +1 raises vout by one trim step.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high when the last run converged.
REQ-013 fail  output  1  high when the last run failed.
REQ-014 fail_code  output  2  0 none, 1 trim rail reached, 2 step limit, 3 invalid comparator state.
REQ-015 steps_used  output  5  unsigned count of trim adjustments made in the current or last run.

Function
REQ-016 cmp_hi and cmp_lo SHALL each pass through a 2-flop synchronizer; only synchronized values are used.
REQ-017 States: IDLE, SETTLE, SAMPLE, DONE, FAIL; busy = 1 exactly in SETTLE and SAMPLE.
REQ-018 IDLE/DONE/FAIL + start (abort low): next cycle state = SETTLE, trim = TRIM_INIT, steps_used = 0, settle counter = SETTLE_CYCLES-1, done = fail = 0, fail_code = 0.
REQ-019 start while busy SHALL be ignored.
REQ-020 SETTLE: counter decrements each cycle; when counter = 0, next state = SAMPLE (SETTLE lasts exactly SETTLE_CYCLES cycles).
REQ-021 SAMPLE lasts one cycle and evaluates in priority order: both synced inputs high -> FAIL, code 3; both low -> DONE; cmp_lo with trim = +7 or cmp_hi with trim = -8 -> FAIL, code 1; steps_used = MAX_STEPS -> FAIL, code 2; else cmp_lo -> trim+1, cmp_hi -> trim-1, steps_used+1, counter reloaded, next state SETTLE.
REQ-022 trim SHALL never wrap; values outside -8..+7 are unreachable.
REQ-023 DONE: done = 1, fail = 0; FAIL: fail = 1, done = 0; both held until next start or reset; trim held.
REQ-024 abort in any state SHALL move to IDLE next cycle, clear busy/done/fail/fail_code, hold trim and steps_used; abort wins over simultaneous start.
REQ-025 done and fail SHALL never be high together; in IDLE both are 0.
REQ-026 Comparator changes during SETTLE SHALL have no effect on trim.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, trim = TRIM_INIT, busy = done = fail = 0, fail_code = 0, steps_used = 0, synchronizers = 0, counter = 0, including mid-run.
REQ-028 After rst_n deasserts, the block SHALL stay in IDLE until a start pulse.

Verification
REQ-029 TRIM_INIT=0, vout model 3.3 V - 0.2 V*k below target with k=3 (cmp_lo until trim=+3) -> trim steps 0,1,2,3 at SETTLE_CYCLES+1 cycle spacing, done=1, steps_used=3.
REQ-030 cmp_hi held high continuously -> trim walks to -8, fail=1, fail_code=1, steps_used=8.
REQ-031 MAX_STEPS=2, cmp_lo held high -> trim=+2, fail=1, fail_code=2, steps_used=2.
REQ-032 cmp_hi=cmp_lo=1 at first sample -> fail=1, fail_code=3, trim=TRIM_INIT, steps_used=0.
REQ-033 abort in SETTLE after two steps -> IDLE next cycle, busy=0, trim=+2 held; start and abort same cycle from IDLE -> stays IDLE.
REQ-034 rst_n pulsed low mid-SETTLE -> all outputs at reset values immediately, no further trim change until a new start.
